adc_lvds_ser_gen: RTL and testbench
===================================

// Module: adc_lvds_ser_gen
// PURPOSE
//  Parametrised multi-channel serial-LVDS ADC source model for QMCA-style benches: per-channel
//  BITS-wide samples shifted out on bit clock CLK (DCO), plus frame clock FCO derived from encode sync.
//  Supersedes fixed 4x14-bit/16-bit-frame serializer: adds channel/width/frame generics,
//  bit order, ramp/pattern test modes, enable, frame counter. Drives gpac_adc_rx inputs in tb.
// PARAMETERS
//  CHANNELS   4       number of serial lanes
//  BITS       14      sample width per channel
//  FRAME      16      CLK cycles per frame; FRAME>=BITS and even, else $error at elaboration
//  LOAD_AT    FRAME/2-1  counter value on which shift registers load
//  SYNC_DLY   0       counter value forced on sync edge (frame phase trim)
//  MSB_FIRST  1       1: shift out MSB first; 0: LSB first
// PORTS
//  CLK        in   1               bit clock (DCO rate)
//  RST        in   1               asynchronous reset, active high
//  ENC_SYNC   in   1               encode clock; rising edge realigns frame
//  EN         in   1               1: normal output; 0: load zeros
//  MODE       in   2               00 DATA_IN, 01 alternating pattern, 10 ramp, 11 all-ones
//  DATA_IN    in   CHANNELS*BITS   ch c at [c*BITS +: BITS]
//  DATA_OUT   out  CHANNELS        serial bit per channel
//  FCO        out  1               frame clock
//  LOAD       out  1               high on load cycle (cnt==LOAD_AT)
//  FRAME_CNT  out  16              loads since reset, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async): cnt, sync pipe, shift regs, ramp, FRAME_CNT all 0 -> DATA_OUT=0, FCO=0, LOAD=0.
//  Sync: 2-flop pipe s[1:0] on ENC_SYNC; edge = s[0] & ~s[1] (2-3 CLK latency from ENC_SYNC rise).
//  Counter cnt ($clog2(FRAME) bits): edge -> cnt<=SYNC_DLY; else cnt==FRAME-1 -> 0; else cnt+1.
//  FCO = (cnt >= FRAME/2), registered-cnt decode, no extra latency.
//  LOAD = (cnt==LOAD_AT) decoded from current cnt; sync edge same cycle does not suppress it,
//   it only sets next cnt.
//  On LOAD cycle edge, per channel c, shift reg sr[c] <= src, where src selected by MODE sampled
//   this cycle (MODE/DATA_IN changes between loads ignored):
//   EN=0 -> 0; 00 -> DATA_IN slice; 01 -> 1010..b (MSB=1), inverted for odd c;
//   10 -> (ramp + c) mod 2^BITS; 11 -> all ones.
//  Non-load cycles: MSB_FIRST=1 sr <= {sr[BITS-2:0],0}, DATA_OUT=sr[BITS-1];
//   MSB_FIRST=0 sr <= {0,sr[BITS-1:1]}, DATA_OUT=sr[0].
//  First sample bit on DATA_OUT the cycle after LOAD edge; bits BITS..FRAME-1 of frame are 0.
//  ramp: BITS wide, +1 on every LOAD when MODE==10, wraps 2^BITS-1 -> 0; held otherwise.
//  FRAME_CNT +1 on every LOAD regardless of EN/MODE.
//  Sync edge mid-shift: shifting continues; next load at new phase, no partial-frame truncation
//   beyond what new phase causes. RST mid-frame: immediate clear, restart needs no sync edge.
//  ENC_SYNC held constant: free-running frames of FRAME cycles.
// TESTING (CHANNELS=4, BITS=14, FRAME=16, LOAD_AT=7, SYNC_DLY=0)
//  1 RST pulse mid-frame -> DATA_OUT=0, FCO=0, FRAME_CNT=0 same cycle; cnt resumes 0,1,2.. after release.
//  2 ENC_SYNC=CLK/16, MODE=00, ch0=14'h2ABC -> after LOAD, ch0 serial 10101010111100 then 00,
//    FCO high cycles cnt 8..15; each ch checked independently (ch1=0x3FFF, ch2=0, ch3=0x0001).
//  3 MODE=10, 5 frames -> ch0 words 0,1,2,3,4; ch3 words 3,4,5,6,7; preload ramp 0x3FFF -> next 0.
//  4 MODE=01 -> ch0 = 0x2AAA, ch1 = 0x1555; MSB_FIRST=0 build -> ch0 LSB first, bit0 appears first.
//  5 Shift ENC_SYNC phase 5 CLK mid-run -> cnt jumps to 0 at edge+2, LOAD fires same edge if cnt==7, FCO realigned next frame.
//  6 EN=0 for 2 frames, MODE change between loads -> zeros out, FRAME_CNT still +2, MODE applied at next LOAD only.

Source files
------------

// File: rtl/adc_lvds_ser_gen.sv
// adc_lvds_ser_gen: multi-channel serial-LVDS ADC source model.
// Each channel's BITS-wide sample is shifted out on the bit clock CLK. The
// frame clock FCO and the load strobe come from a frame counter that an
// ENC_SYNC rising edge realigns.
module adc_lvds_ser_gen #(
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned BITS      = 14,
   parameter int unsigned FRAME     = 16,
   parameter int unsigned LOAD_AT   = FRAME / 2 - 1,
   parameter int unsigned SYNC_DLY  = 0,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       ENC_SYNC,
   input  logic                       EN,
   input  logic [1:0]                 MODE,
   input  logic [CHANNELS*BITS-1:0]   DATA_IN,
   output logic [CHANNELS-1:0]        DATA_OUT,
   output logic                       FCO,
   output logic                       LOAD,
   output logic [15:0]                FRAME_CNT
);

   localparam int unsigned CW = (FRAME > 1) ? $clog2(FRAME) : 1;

   // Reject frame geometries that cannot hold a whole sample or split evenly into FCO halves
   if ((FRAME < BITS) || ((FRAME % 2) != 0)) begin : g_param_check
      $error("adc_lvds_ser_gen: FRAME must be even and >= BITS");
   end

   // Alternating test word with its MSB set, e.g. 14'h2AAA for BITS=14
   function automatic logic [BITS-1:0] alt_pattern();
      logic [BITS-1:0] p;
      p = '0;
      for (int unsigned i = 0; i < BITS; i++) begin
         p[i] = (((BITS - 1 - i) % 2) == 0);
      end
      return p;
   endfunction

   localparam logic [BITS-1:0] ALT = alt_pattern();

   logic [CW-1:0]   cnt;
   logic [1:0]      sync_s;
   logic            sync_edge;
   logic [BITS-1:0] ramp;

   assign sync_edge = sync_s[0] & ~sync_s[1];
   assign FCO       = (cnt >= CW'(FRAME / 2));
   assign LOAD      = (cnt == CW'(LOAD_AT));

   // Encode-clock synchroniser: two flops, rising edge taken from the pair
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) sync_s <= '0;
      else     sync_s <= {sync_s[0], ENC_SYNC};
   end

   // Frame phase counter; a sync edge forces the trim phase instead of counting
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                        cnt <= '0;
      else if (sync_edge)             cnt <= CW'(SYNC_DLY);
      else if (cnt == CW'(FRAME - 1)) cnt <= '0;
      else                            cnt <= cnt + 1'b1;
   end

   // Ramp generator and load counter, both advanced only on load cycles
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ramp      <= '0;
         FRAME_CNT <= '0;
      end else if (LOAD) begin
         FRAME_CNT <= FRAME_CNT + 16'd1;
         if (MODE == 2'b10) ramp <= ramp + 1'b1;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [BITS-1:0] src;
      logic [BITS-1:0] sr;

      // Word to load for this lane, chosen by enable and test mode
      always_comb begin
         src = '0;
         if (EN) begin
            case (MODE)
               2'b00:   src = DATA_IN[c*BITS +: BITS];
               2'b01:   src = ((c % 2) == 1) ? ~ALT : ALT;
               2'b10:   src = ramp + BITS'(c);
               default: src = '1;
            endcase
         end
      end

      // Lane shift register: parallel load on LOAD, otherwise shift zeros in behind the data
      always_ff @(posedge CLK or posedge RST) begin
         if (RST)                 sr <= '0;
         else if (LOAD)           sr <= src;
         else if (MSB_FIRST != 0) sr <= {sr[BITS-2:0], 1'b0};
         else                     sr <= {1'b0, sr[BITS-1:1]};
      end

      assign DATA_OUT[c] = (MSB_FIRST != 0) ? sr[BITS-1] : sr[0];
   end

endmodule

// File: tb/tb_adc_lvds_ser_gen.sv
// Bench for adc_lvds_ser_gen: table-driven frame captures, a ramp wrap run on a
// narrow build, and randomized sync phases/inputs checked every cycle against
// a frame/phase reference model.
module tb_adc_lvds_ser_gen;

   localparam int CH = 4;
   localparam int B  = 14;
   localparam int FR = 16;
   localparam int LA = 7;

   logic        clk;
   logic        rst, enc_sync, en;
   logic [1:0]  mode;
   logic [55:0] data_in;

   logic [3:0]  do_m, do_l, do_s;
   logic        fco_m, fco_l, fco_s, load_m, load_l, load_s;
   logic [15:0] fc_m, fc_l, fc_s;

   int n_tests, n_fail;
   int cyc, enc_off;
   bit hold_sync;

   // reference model state
   int m_phase;
   bit m_hist0, m_hist1;
   int m_word[CH];
   int m_k;
   int m_ramp;
   int m_fcnt;

   adc_lvds_ser_gen dut_m (
      .CLK(clk), .RST(rst), .ENC_SYNC(enc_sync), .EN(en), .MODE(mode),
      .DATA_IN(data_in), .DATA_OUT(do_m), .FCO(fco_m), .LOAD(load_m), .FRAME_CNT(fc_m));

   adc_lvds_ser_gen #(.MSB_FIRST(0)) dut_l (
      .CLK(clk), .RST(rst), .ENC_SYNC(enc_sync), .EN(en), .MODE(mode),
      .DATA_IN(data_in), .DATA_OUT(do_l), .FCO(fco_l), .LOAD(load_l), .FRAME_CNT(fc_l));

   adc_lvds_ser_gen #(.BITS(4), .FRAME(4)) dut_s (
      .CLK(clk), .RST(rst), .ENC_SYNC(enc_sync), .EN(en), .MODE(mode),
      .DATA_IN(data_in[15:0]), .DATA_OUT(do_s), .FCO(fco_s), .LOAD(load_s), .FRAME_CNT(fc_s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // word a lane should load under the given controls
   function automatic int src_word(int c, bit e, logic [1:0] md, logic [55:0] din, int rmp);
      int alt = 0;
      if (!e) return 0;
      case (md)
         2'd0: return int'(din[c*B +: B]);
         2'd1: begin
            for (int i = B - 1; i >= 0; i -= 2) alt += (1 << i);
            return ((c % 2) == 1) ? (alt ^ ((1 << B) - 1)) : alt;
         end
         2'd2: return (rmp + c) % (1 << B);
         default: return (1 << B) - 1;
      endcase
   endfunction

   task automatic model_reset();
      m_phase = 0; m_hist0 = 0; m_hist1 = 0; m_k = 1000; m_ramp = 0; m_fcnt = 0;
      for (int c = 0; c < CH; c++) m_word[c] = 0;
   endtask

   // advance the model across one rising edge using the inputs held at that edge
   task automatic model_update();
      bit sedge;
      sedge = m_hist0 && !m_hist1;
      if (m_phase == LA) begin
         for (int c = 0; c < CH; c++) m_word[c] = src_word(c, en, mode, data_in, m_ramp);
         m_k = 0;
         if (mode == 2'd2) m_ramp = (m_ramp + 1) % (1 << B);
         m_fcnt = (m_fcnt + 1) % 65536;
      end else if (m_k < 1000) begin
         m_k++;
      end
      m_phase = sedge ? 0 : (m_phase + 1) % FR;
      m_hist1 = m_hist0;
      m_hist0 = enc_sync;
   endtask

   task automatic check_cycle();
      logic [3:0] em, el;
      for (int c = 0; c < CH; c++) begin
         if (m_k < B) begin
            em[c] = 1'((m_word[c] >> (B - 1 - m_k)) & 1);
            el[c] = 1'((m_word[c] >> m_k) & 1);
         end else begin
            em[c] = 1'b0;
            el[c] = 1'b0;
         end
      end
      cmp("data_out_msb", 32'(do_m), 32'(em));
      cmp("data_out_lsb", 32'(do_l), 32'(el));
      cmp("load",         32'(load_m), 32'(m_phase == LA));
      cmp("load_lsb",     32'(load_l), 32'(m_phase == LA));
      cmp("fco",          32'(fco_m), 32'(m_phase >= FR / 2));
      cmp("fco_lsb",      32'(fco_l), 32'(m_phase >= FR / 2));
      cmp("frame_cnt",    32'(fc_m), 32'(m_fcnt));
      cmp("frame_cnt_lsb",32'(fc_l), 32'(m_fcnt));
   endtask

   task automatic tick();
      if (!hold_sync) enc_sync = ((cyc + enc_off) % 16) < 8;
      cyc++;
      check_cycle();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   // called at a falling edge: reset asserted mid-cycle must clear outputs at once
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      cmp("rst_data_out_msb", 32'(do_m), 32'd0);
      cmp("rst_data_out_lsb", 32'(do_l), 32'd0);
      cmp("rst_data_out_small", 32'(do_s), 32'd0);
      cmp("rst_fco", 32'(fco_m), 32'd0);
      cmp("rst_load", 32'(load_m), 32'd0);
      cmp("rst_frame_cnt", 32'(fc_m), 32'd0);
      cmp("rst_frame_cnt_small", 32'(fc_s), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // wait for the next load, then collect one frame's words from both bit orders
   task automatic capture(output logic [3:0][13:0] wm, output logic [3:0][13:0] wl);
      int guard;
      guard = 0;
      wm = '0;
      wl = '0;
      while (load_m !== 1'b1 && guard < 40) begin
         tick();
         guard++;
      end
      cmp("load_wait", 32'(load_m), 32'd1);
      tick();
      for (int i = 0; i < B; i++) begin
         for (int c = 0; c < CH; c++) begin
            wm[c][B-1-i] = do_m[c];
            wl[c][i]     = do_l[c];
         end
         tick();
      end
      for (int i = 0; i < FR - B; i++) begin
         cmp("tail_zero_msb", 32'(do_m), 32'd0);
         cmp("tail_zero_lsb", 32'(do_l), 32'd0);
         if (i < FR - B - 1) tick();
      end
   endtask

   typedef struct {
      bit               en;
      logic [1:0]       mode;
      logic [55:0]      din;
      logic [3:0][13:0] exp;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [3:0][13:0] wm, wl;
      int fc0, got0, got1, p, w;

      n_tests = 0; n_fail = 0; cyc = 0; enc_off = 3; hold_sync = 0;
      rst = 1'b1; en = 1'b1; mode = 2'd0; data_in = '0; enc_sync = 1'b0;
      model_reset();

      vecs[0] = '{1'b1, 2'd0, {14'h0001, 14'h0000, 14'h3FFF, 14'h2ABC},
                  {14'h0001, 14'h0000, 14'h3FFF, 14'h2ABC}};
      vecs[1] = '{1'b1, 2'd1, {14'h1234, 14'h0F0F, 14'h3C3C, 14'h0101},
                  {14'h1555, 14'h2AAA, 14'h1555, 14'h2AAA}};
      vecs[2] = '{1'b1, 2'd3, {14'h0000, 14'h0000, 14'h0000, 14'h0000},
                  {14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF}};
      vecs[3] = '{1'b0, 2'd3, {14'h0001, 14'h0002, 14'h0003, 14'h0004},
                  {14'h0000, 14'h0000, 14'h0000, 14'h0000}};
      vecs[4] = '{1'b0, 2'd0, {14'h0001, 14'h0000, 14'h3FFF, 14'h2ABC},
                  {14'h0000, 14'h0000, 14'h0000, 14'h0000}};
      vecs[5] = '{1'b1, 2'd1, {14'h0001, 14'h0000, 14'h3FFF, 14'h2ABC},
                  {14'h1555, 14'h2AAA, 14'h1555, 14'h2AAA}};
      vecs[6] = '{1'b1, 2'd0, {14'h1234, 14'h0F0F, 14'h3000, 14'h0155},
                  {14'h1234, 14'h0F0F, 14'h3000, 14'h0155}};

      @(negedge clk);
      do_reset();
      repeat (32) tick();

      // table: fixed words, patterns, all-ones, disabled frames with mode change
      fc0 = 0;
      for (int v = 0; v < 7; v++) begin
         en = vecs[v].en;
         mode = vecs[v].mode;
         data_in = vecs[v].din;
         if (v == 3) fc0 = m_fcnt;
         capture(wm, wl);
         for (int c = 0; c < CH; c++) begin
            cmp($sformatf("vec%0d_ch%0d_msb", v, c), 32'(wm[c]), 32'(vecs[v].exp[c]));
            cmp($sformatf("vec%0d_ch%0d_lsb", v, c), 32'(wl[c]), 32'(vecs[v].exp[c]));
         end
         if (v == 4) cmp("frame_cnt_en0", 32'(fc_m), 32'((fc0 + 2) % 65536));
      end

      // reset mid-frame, then ramp mode with a held encode clock
      repeat (5) tick();
      do_reset();
      hold_sync = 1; enc_sync = 1'b0; en = 1'b1; mode = 2'd2;
      for (int f = 0; f < 5; f++) begin
         capture(wm, wl);
         for (int c = 0; c < CH; c++) begin
            cmp($sformatf("ramp%0d_ch%0d_msb", f, c), 32'(wm[c]), 32'(f + c));
            cmp($sformatf("ramp%0d_ch%0d_lsb", f, c), 32'(wl[c]), 32'(f + c));
         end
      end

      // narrow 4-bit, 4-cycle build: ramp wraps 15 -> 0
      do_reset();
      got0 = 0; got1 = 0;
      for (int n = 0; n < 74; n++) begin
         cmp("small_load", 32'(load_s), 32'((n % 4) == 1));
         if (n < 2) begin
            cmp("small_pre_load_zero", 32'(do_s), 32'd0);
         end else begin
            p = 3 - ((n - 2) % 4);
            w = (n - 2) / 4;
            if (do_s[0]) got0 |= (1 << p);
            if (do_s[1]) got1 |= (1 << p);
            if (p == 0) begin
               cmp($sformatf("small_ramp_w%0d_ch0", w), 32'(got0), 32'(w % 16));
               cmp($sformatf("small_ramp_w%0d_ch1", w), 32'(got1), 32'((w + 1) % 16));
               got0 = 0; got1 = 0;
            end
         end
         tick();
      end

      // randomized inputs under shifting encode-clock phases
      hold_sync = 0;
      for (int s = 0; s < 16; s++) begin
         enc_off = (s == 0) ? (enc_off + 5) % 16 : int'($urandom_range(0, 15));
         if (s == 8) do_reset();
         repeat (48) begin
            en = ($urandom_range(0, 9) != 0);
            mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) data_in = 56'({$urandom(), $urandom()});
            tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
